slots_round_ctrl: RTL and testbench

- Sequencer for one slots round in the BlackJack arcade top level.
- Owns three spinning reels and debounced edge detection on the player keys.
- Stops reels in order, evaluates the result, and maintains the credit balance.
- Drives the reel values to the HEX decoders and a 5-bit LEDR pattern. Reel stepping is paced by an external rate-divider enable.

---
 rtl/slots_round_ctrl.sv | 179 +++++++++++++++++
 tb/tb_slots_round_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slots_round_ctrl.sv
// rtl/slots_round_ctrl.sv - slots round sequencer: key edge detect, three reels, result and credits
// Define SLOTS_PAIR_PAY_EN to pay +2 credits when exactly two reels match.
module slots_round_ctrl #(
  parameter int SYM_W         = 5,
  parameter int NUM_SYMBOLS   = 8,
  parameter int WIN_SYMBOL    = 7,
  parameter int START_CREDITS = 10,
  parameter int JACKPOT       = 20
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             spin_en,
  input  logic             key_start,
  input  logic             key_1,
  input  logic             key_2,
  input  logic             key_3,
  output logic [SYM_W-1:0] reel1,
  output logic [SYM_W-1:0] reel2,
  output logic [SYM_W-1:0] reel3,
  output logic [4:0]       leds,
  output logic [7:0]       credits,
  output logic [2:0]       state_out,
  output logic             no_credit
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SPIN1 = 3'd1;
  localparam logic [2:0] ST_SPIN2 = 3'd2;
  localparam logic [2:0] ST_SPIN3 = 3'd3;
  localparam logic [2:0] ST_EVAL  = 3'd4;
  localparam logic [2:0] ST_WIN   = 3'd5;
  localparam logic [2:0] ST_LOSE  = 3'd6;

  localparam logic [SYM_W:0]   NSYM    = (SYM_W+1)'(NUM_SYMBOLS);
  localparam logic [SYM_W:0]   INC1    = (SYM_W+1)'(1);
  localparam logic [SYM_W:0]   INC3    = (SYM_W+1)'(3);
  localparam logic [SYM_W:0]   INC5    = (SYM_W+1)'(5);
  localparam logic [SYM_W-1:0] WIN_SYM = SYM_W'(WIN_SYMBOL);
  localparam logic [7:0]       CR_INIT = 8'(START_CREDITS);
  localparam logic [7:0]       CR_JACK = 8'(JACKPOT);

  // Wrap with one conditional subtract so a reel never shows an out-of-range symbol.
  function automatic logic [SYM_W-1:0] reel_step(input logic [SYM_W-1:0] v,
                                                 input logic [SYM_W:0]   inc);
    logic [SYM_W:0] s;
    s = {1'b0, v} + inc;
    if (s >= NSYM) s = s - NSYM;
    return s[SYM_W-1:0];
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Key bit order: [0]=start, [1]=stop reel1, [2]=stop reel2, [3]=stop reel3 / acknowledge.
  logic [3:0] key_raw, press;
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [2:0] state_q, state_d;
  logic [7:0] credits_q, credits_d;
  logic [SYM_W-1:0] reel1_q, reel1_d, reel2_q, reel2_d, reel3_q, reel3_d;
  logic step1, step2, step3, all_win;
`ifdef SLOTS_PAIR_PAY_EN
  logic pair_q, pair_d, pair_hit;
`endif

  assign key_raw = {key_3, key_2, key_1, key_start};

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    press   = prev_q & ~sync2_q;
  end

  // A stop press on the same cycle as spin_en keeps the reel at its pre-step value.
  always_comb begin
    step1   = spin_en && (state_q == ST_SPIN1) && !press[1];
    step2   = spin_en && ((state_q == ST_SPIN1) || ((state_q == ST_SPIN2) && !press[2]));
    step3   = spin_en && ((state_q == ST_SPIN1) || (state_q == ST_SPIN2) ||
                          ((state_q == ST_SPIN3) && !press[3]));
    reel1_d = step1 ? reel_step(reel1_q, INC1) : reel1_q;
    reel2_d = step2 ? reel_step(reel2_q, INC3) : reel2_q;
    reel3_d = step3 ? reel_step(reel3_q, INC5) : reel3_q;
  end

  always_comb begin
    all_win   = (reel1_q == WIN_SYM) && (reel2_q == WIN_SYM) && (reel3_q == WIN_SYM);
    state_d   = state_q;
    credits_d = credits_q;
`ifdef SLOTS_PAIR_PAY_EN
    pair_hit  = ((reel1_q == reel2_q) || (reel2_q == reel3_q) || (reel1_q == reel3_q)) &&
                !((reel1_q == reel2_q) && (reel2_q == reel3_q));
    pair_d    = pair_q;
`endif
    case (state_q)
      ST_IDLE:  if (press[0] && (credits_q != 8'd0)) begin
                  credits_d = credits_q - 8'd1;
                  state_d   = ST_SPIN1;
                end
      ST_SPIN1: if (press[1]) state_d = ST_SPIN2;
      ST_SPIN2: if (press[2]) state_d = ST_SPIN3;
      ST_SPIN3: if (press[3]) state_d = ST_EVAL;
      ST_EVAL: begin
`ifdef SLOTS_PAIR_PAY_EN
        pair_d = 1'b0;
`endif
        if (all_win) begin
          credits_d = sat_add(credits_q, CR_JACK);
          state_d   = ST_WIN;
        end
`ifdef SLOTS_PAIR_PAY_EN
        else if (pair_hit) begin
          credits_d = sat_add(credits_q, 8'd2);
          pair_d    = 1'b1;
          state_d   = ST_WIN;
        end
`endif
        else begin
          state_d = ST_LOSE;
        end
      end
      ST_WIN, ST_LOSE: if (press[3]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      prev_q    <= 4'hF;
      state_q   <= ST_IDLE;
      credits_q <= CR_INIT;
      reel1_q   <= '0;
      reel2_q   <= '0;
      reel3_q   <= '0;
`ifdef SLOTS_PAIR_PAY_EN
      pair_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      credits_q <= credits_d;
      reel1_q   <= reel1_d;
      reel2_q   <= reel2_d;
      reel3_q   <= reel3_d;
`ifdef SLOTS_PAIR_PAY_EN
      pair_q    <= pair_d;
`endif
    end
  end

  always_comb begin
    case (state_q)
      ST_SPIN1: leds = 5'b00111;
      ST_SPIN2: leds = 5'b00011;
      ST_SPIN3: leds = 5'b00001;
`ifdef SLOTS_PAIR_PAY_EN
      ST_WIN:   leds = pair_q ? 5'b01110 : 5'b11111;
`else
      ST_WIN:   leds = 5'b11111;
`endif
      ST_LOSE:  leds = 5'b10101;
      default:  leds = 5'b00000;
    endcase
  end

  assign reel1     = reel1_q;
  assign reel2     = reel2_q;
  assign reel3     = reel3_q;
  assign credits   = credits_q;
  assign state_out = state_q;
  assign no_credit = (state_q == ST_IDLE) && (credits_q == 8'd0);

endmodule

// File: tb/tb_slots_round_ctrl.sv
// tb/tb_slots_round_ctrl.sv - scoreboarded bench for slots_round_ctrl
// Reference model tracks reels with modulo arithmetic and key presses by edge history.
module tb_slots_round_ctrl;

  localparam int N       = 8;
  localparam int WIN_SYM = 7;
  localparam int JP      = 20;
  localparam int START   = 10;

  logic       clk       = 1'b0;
  logic       resetn    = 1'b0;
  logic       spin_en   = 1'b0;
  logic       key_start = 1'b1;
  logic       key_1     = 1'b1;
  logic       key_2     = 1'b1;
  logic       key_3     = 1'b1;
  logic [4:0] reel1, reel2, reel3, leds;
  logic [7:0] credits;
  logic [2:0] state_out;
  logic       no_credit;

  slots_round_ctrl #(
    .SYM_W(5), .NUM_SYMBOLS(N), .WIN_SYMBOL(WIN_SYM), .START_CREDITS(START), .JACKPOT(JP)
  ) dut (
    .clk(clk), .resetn(resetn), .spin_en(spin_en),
    .key_start(key_start), .key_1(key_1), .key_2(key_2), .key_3(key_3),
    .reel1(reel1), .reel2(reel2), .reel3(reel3), .leds(leds),
    .credits(credits), .state_out(state_out), .no_credit(no_credit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int r1; int r2; int r3; int leds; int cr; int nc;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  int m_st;
  int m_r[3];
  int m_cr;
  bit m_pair;
  bit hist[4][3];

  function automatic int exp_leds(input int st, input bit pair);
    case (st)
      1: return 5'b00111;
      2: return 5'b00011;
      3: return 5'b00001;
      4: return -1;
      5: return pair ? 5'b01110 : 5'b11111;
      6: return 5'b10101;
      default: return 0;
    endcase
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.st = m_st; s.r1 = m_r[0]; s.r2 = m_r[1]; s.r3 = m_r[2];
    s.leds = exp_leds(m_st, m_pair);
    s.cr = m_cr;
    s.nc = (m_st == 0 && m_cr == 0) ? 1 : 0;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic compare_snap(input string tag, input snap_t s);
    chk({tag, "_state"}, int'(state_out), s.st);
    chk({tag, "_reel1"}, int'(reel1), s.r1);
    chk({tag, "_reel2"}, int'(reel2), s.r2);
    chk({tag, "_reel3"}, int'(reel3), s.r3);
    if (s.leds >= 0) chk({tag, "_leds"}, int'(leds), s.leds);
    chk({tag, "_credits"}, int'(credits), s.cr);
    chk({tag, "_no_credit"}, int'(no_credit), s.nc);
  endtask

  task automatic check_now(input string tag);
    compare_snap(tag, model_snap());
  endtask

  task automatic model_reset();
    m_st = 0; m_r = '{0, 0, 0}; m_cr = START; m_pair = 1'b0;
    foreach (hist[k, j]) hist[k][j] = 1'b1;
  endtask

  // A press acts on the clock edge where the raw key was low two edges back and high three edges back.
  task automatic model_edge(input bit spin, input bit [3:0] raw);
    bit [3:0] pr;
    int old;
`ifdef SLOTS_PAIR_PAY_EN
    int distinct;
`endif
    for (int k = 0; k < 4; k++) begin
      pr[k] = !hist[k][1] && hist[k][2];
      hist[k][2] = hist[k][1];
      hist[k][1] = hist[k][0];
      hist[k][0] = raw[k];
    end
    old = m_st;
    for (int i = 0; i < 3; i++)
      if (spin && m_st >= 1 && m_st <= i + 1 && !(m_st == i + 1 && pr[i+1]))
        m_r[i] = (m_r[i] + 2 * i + 1) % N;
    case (m_st)
      0: if (pr[0] && m_cr > 0) begin m_cr--; m_st = 1; end
      1, 2, 3: if (pr[m_st]) m_st++;
      4: begin
`ifdef SLOTS_PAIR_PAY_EN
        distinct = 1 + ((m_r[1] != m_r[0]) ? 1 : 0) +
                   ((m_r[2] != m_r[0] && m_r[2] != m_r[1]) ? 1 : 0);
`endif
        m_pair = 1'b0;
        if (m_r[0] == WIN_SYM && m_r[1] == WIN_SYM && m_r[2] == WIN_SYM) begin
          m_cr = (m_cr + JP > 255) ? 255 : m_cr + JP;
          m_st = 5;
        end
`ifdef SLOTS_PAIR_PAY_EN
        else if (distinct == 2) begin
          m_cr = (m_cr + 2 > 255) ? 255 : m_cr + 2;
          m_pair = 1'b1;
          m_st = 5;
        end
`endif
        else m_st = 6;
      end
      5, 6: if (pr[3]) m_st = 0;
      default: ;
    endcase
    if (m_st != old) exp_q.push_back(model_snap());
  endtask

  function automatic bit spin_pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cycle(input bit spin, input bit [3:0] raw);
    spin_en = spin;
    {key_3, key_2, key_1, key_start} = raw;
    @(posedge clk);
    model_edge(spin, raw);
    #1;
  endtask

  task automatic idle(input int n, input int mode);
    repeat (n) cycle(spin_pick(mode), 4'hF);
  endtask

  task automatic press_raw(input bit [3:0] raw, input int hold, input int mode);
    repeat (hold) cycle(spin_pick(mode), raw);
    idle(4, mode);
  endtask

  task automatic press_key(input int k, input int hold, input int mode);
    bit [3:0] raw;
    raw = 4'hF;
    raw[k] = 1'b0;
    press_raw(raw, hold, mode);
  endtask

  task automatic drive_to(input int i, input int target);
    int n;
    n = 0;
    while (m_r[i] != target && n < 2 * N) begin
      cycle(1'b1, 4'hF);
      cycle(1'b0, 4'hF);
      n++;
    end
    press_key(i + 1, 3, 0);
  endtask

  task automatic async_reset(input bit push);
    spin_en = 1'b0;
    {key_3, key_2, key_1, key_start} = 4'hF;
    model_reset();
    if (push) exp_q.push_back(model_snap());
    resetn = 1'b0;
    #2;
    check_now("async_reset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin : monitor
    int    last;
    snap_t s;
    last = 0;
    forever begin
      @(negedge clk);
      if (int'(state_out) != last) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL mon_unexpected: state moved %0d -> %0d, nothing expected", last, state_out);
        end else begin
          s = exp_q.pop_front();
          compare_snap("mon", s);
        end
        last = int'(state_out);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : stimulus
    bit [3:0] raw;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_now("reset");
    chk("reset_credits", int'(credits), START);
    resetn = 1'b1;

    press_key(0, 3, 0);
    repeat (4) begin cycle(1'b1, 4'hF); cycle(1'b0, 4'hF); end
    press_key(1, 3, 0);
    chk("tp_reel1", int'(reel1), 4);
    chk("tp_reel2", int'(reel2), 4);
    chk("tp_reel3", int'(reel3), 4);
    chk("tp_credits", int'(credits), 9);
    chk("tp_state", int'(state_out), 2);
    chk("tp_leds", int'(leds), 5'b00011);

    repeat (3) begin cycle(1'b1, 4'hF); cycle(1'b0, 4'hF); end
    async_reset(1'b1);
    chk("midreset_credits", int'(credits), START);

    press_key(0, 3, 0);
    drive_to(0, 7); drive_to(1, 7); drive_to(2, 7);
    idle(2, 0);
    chk("jp_state", int'(state_out), 5);
    chk("jp_credits", int'(credits), 29);
    chk("jp_leds", int'(leds), 5'b11111);
    press_key(3, 3, 0);
    chk("jp_ack_state", int'(state_out), 0);
    check_now("jp_ack");

    press_key(0, 3, 0);
    drive_to(0, 3); drive_to(1, 3); drive_to(2, 5);
    idle(2, 0);
`ifdef SLOTS_PAIR_PAY_EN
    chk("pair_state", int'(state_out), 5);
    chk("pair_credits", int'(credits), 30);
    chk("pair_leds", int'(leds), 5'b01110);
`else
    chk("pair_state", int'(state_out), 6);
    chk("pair_credits", int'(credits), 28);
    chk("pair_leds", int'(leds), 5'b10101);
`endif
    press_key(3, 3, 0);

    press_key(0, 3, 0);
    repeat (100) cycle(1'b1, 4'b1101);
    idle(4, 0);
    chk("held_state", int'(state_out), 2);
    check_now("held");
    press_raw(4'b0000, 3, 1);
    chk("simul_state", int'(state_out), 3);
    press_key(1, 3, 2);
    chk("stray_state", int'(state_out), 3);
    drive_to(2, $urandom_range(0, N - 1));
    idle(2, 0);
    press_key(3, 3, 0);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) begin
        raw = 4'($urandom_range(0, 15));
        raw[k] = 1'b0;
        press_raw(raw, $urandom_range(2, 4), 2);
        idle($urandom_range(0, 5), 2);
        if (k == 3) check_now($sformatf("rnd%0d", r));
      end
      press_key(3, $urandom_range(2, 4), 2);
      idle(2, 2);
    end

    async_reset(1'b0);
    for (int r = 0; r < 10; r++) begin
      press_key(0, 3, 0);
      drive_to(0, 0); drive_to(1, 1); drive_to(2, 2);
      idle(2, 0);
      press_key(3, 3, 0);
    end
    chk("drain_credits", int'(credits), 0);
    chk("drain_no_credit", int'(no_credit), 1);
    press_key(0, 3, 0);
    chk("nocr_state", int'(state_out), 0);
    chk("nocr_no_credit", int'(no_credit), 1);
    chk("nocr_credits", int'(credits), 0);
    check_now("nocr");

    idle(4, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
